// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use stall controller.
// Keeps a shadow copy of {valid, rd, regwrite, memread} for the EX, MEM and
// WB instructions. From it, the block produces registered 3-to-1 operand-mux
// selects that are valid while the consuming instruction sits in EX. It also
// produces the combinational load-use stall.
module fwd_hazard_ctrl #(
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  id_valid_i,
   input  logic [REG_ADDR_W-1:0] id_rs_i,
   input  logic [REG_ADDR_W-1:0] id_rt_i,
   input  logic [REG_ADDR_W-1:0] id_rd_i,
   input  logic                  id_regwrite_i,
   input  logic                  id_memread_i,
   input  logic                  flush_i,
   output logic [1:0]            fwd_a_sel_o,
   output logic [1:0]            fwd_b_sel_o,
   output logic                  stall_o,
   output logic [CNT_W-1:0]      stall_cnt_o
);

   localparam logic [1:0] SEL_RF     = 2'b00;
   localparam logic [1:0] SEL_MEM_WB = 2'b01;
   localparam logic [1:0] SEL_EX_MEM = 2'b10;

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] rd;
      logic                  regwrite;
      logic                  memread;
   } stage_t;

   stage_t ex_q;
   stage_t mem_q;
   stage_t wb_q;

   logic       ex_writing;
   logic       mem_writing;
   logic       insert_bubble;
   logic [1:0] sel_a_d;
   logic [1:0] sel_b_d;

   // A stage can be a forwarding source only when it really writes a nonzero register.
   always_comb begin
      ex_writing  = ex_q.valid && ex_q.regwrite && (ex_q.rd != '0);
      mem_writing = mem_q.valid && mem_q.regwrite && (mem_q.rd != '0);
   end

   // A load in EX that feeds the ID instruction cannot forward in time, so hold ID for one cycle.
   assign stall_o = id_valid_i && !flush_i && ex_q.valid && ex_q.memread &&
                    ex_q.regwrite && (ex_q.rd != '0) &&
                    ((ex_q.rd == id_rs_i) || (ex_q.rd == id_rt_i));

   assign insert_bubble = flush_i || stall_o;

   // The current EX and MEM instructions will be in MEM and WB when the ID instruction is in EX.
   // The nearer producer (EX) wins.
   always_comb begin
      sel_a_d = SEL_RF;
      sel_b_d = SEL_RF;
      if (ex_writing && (ex_q.rd == id_rs_i))
         sel_a_d = SEL_EX_MEM;
      else if (mem_writing && (mem_q.rd == id_rs_i))
         sel_a_d = SEL_MEM_WB;
      if (ex_writing && (ex_q.rd == id_rt_i))
         sel_b_d = SEL_EX_MEM;
      else if (mem_writing && (mem_q.rd == id_rt_i))
         sel_b_d = SEL_MEM_WB;
      if (!id_valid_i) begin
         sel_a_d = SEL_RF;
         sel_b_d = SEL_RF;
      end
   end

   // Advance the shadow pipeline and register the selects for the instruction entering EX.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ex_q        <= '0;
         mem_q       <= '0;
         wb_q        <= '0;
         fwd_a_sel_o <= SEL_RF;
         fwd_b_sel_o <= SEL_RF;
      end else begin
         wb_q  <= mem_q;
         mem_q <= ex_q;
         if (insert_bubble) begin
            ex_q        <= '0;
            fwd_a_sel_o <= SEL_RF;
            fwd_b_sel_o <= SEL_RF;
         end else begin
            ex_q.valid    <= id_valid_i;
            ex_q.rd       <= id_rd_i;
            ex_q.regwrite <= id_regwrite_i;
            ex_q.memread  <= id_memread_i;
            fwd_a_sel_o   <= sel_a_d;
            fwd_b_sel_o   <= sel_b_d;
         end
      end
   end

   // Saturating count of stall cycles since reset.
   always_ff @(posedge clk_i) begin
      if (rst_i)
         stall_cnt_o <= '0;
      else if (stall_o && (stall_cnt_o != {CNT_W{1'b1}}))
         stall_cnt_o <= stall_cnt_o + CNT_W'(1);
   end

   // The WB copy and the MEM load flag exist only for debug visibility.
   // No logic consumes them.
   logic unused_dbg;
   assign unused_dbg = ^{wb_q, mem_q.memread};

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl (CNT_W = 2 so saturation is reachable).
// Inputs change on the falling edge. Stall is observed 1 ns later, and the
// registered selects are observed on the falling edge after the rising edge
// that latched them.
module tb_fwd_hazard_ctrl;

   localparam int AW = 5;
   localparam int CW = 2;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          id_valid_i;
   logic [AW-1:0] id_rs_i;
   logic [AW-1:0] id_rt_i;
   logic [AW-1:0] id_rd_i;
   logic          id_regwrite_i;
   logic          id_memread_i;
   logic          flush_i;
   logic [1:0]    fwd_a_sel_o;
   logic [1:0]    fwd_b_sel_o;
   logic          stall_o;
   logic [CW-1:0] stall_cnt_o;

   int n_assert = 0;
   int n_fail   = 0;

   logic [1:0] exp_sat [5];

   fwd_hazard_ctrl #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .id_valid_i    (id_valid_i),
      .id_rs_i       (id_rs_i),
      .id_rt_i       (id_rt_i),
      .id_rd_i       (id_rd_i),
      .id_regwrite_i (id_regwrite_i),
      .id_memread_i  (id_memread_i),
      .flush_i       (flush_i),
      .fwd_a_sel_o   (fwd_a_sel_o),
      .fwd_b_sel_o   (fwd_b_sel_o),
      .stall_o       (stall_o),
      .stall_cnt_o   (stall_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_id(input logic v, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                         input logic [AW-1:0] rd, input logic rw, input logic mr, input logic fl);
      id_valid_i    = v;
      id_rs_i       = rs;
      id_rt_i       = rt;
      id_rd_i       = rd;
      id_regwrite_i = rw;
      id_memread_i  = mr;
      flush_i       = fl;
   endtask

   task automatic nop();
      set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic tick();
      @(negedge clk_i);
   endtask

   initial begin
      exp_sat = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

      // Reset held for two edges with random ID inputs.
      rst_i = 1'b1;
      set_id(1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom));
      tick();
      set_id(1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom));
      tick();
      #1;
      check("rst_stall", 16'(stall_o), 16'd0);
      check("rst_sel_a", 16'(fwd_a_sel_o), 16'd0);
      check("rst_sel_b", 16'(fwd_b_sel_o), 16'd0);
      check("rst_cnt", 16'(stall_cnt_o), 16'd0);
      rst_i = 1'b0;
      nop();
      tick();

      // Back-to-back ALU dependence: add r3 ; sub r6 = r3 - r4.
      set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);
      tick();
      set_id(1'b1, 5'd3, 5'd4, 5'd6, 1'b1, 1'b0, 1'b0);
      #1;
      check("b2b_stall", 16'(stall_o), 16'd0);
      tick();
      check("b2b_sel_a", 16'(fwd_a_sel_o), 16'd2);
      check("b2b_sel_b", 16'(fwd_b_sel_o), 16'd0);
      nop();
      tick();
      nop();
      tick();

      // Distance-2 dependence: add r5 ; bubble ; or r8 = r5 | r5.
      set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);
      tick();
      nop();
      tick();
      check("nop_sel_a", 16'(fwd_a_sel_o), 16'd0);
      set_id(1'b1, 5'd5, 5'd5, 5'd8, 1'b1, 1'b0, 1'b0);
      tick();
      check("d2_sel_a", 16'(fwd_a_sel_o), 16'd1);
      check("d2_sel_b", 16'(fwd_b_sel_o), 16'd1);

      // Priority: add r5 ; add r5 ; or r8 = r5 | r9 -> nearest producer wins.
      set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);
      tick();
      set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);
      tick();
      set_id(1'b1, 5'd5, 5'd9, 5'd8, 1'b1, 1'b0, 1'b0);
      tick();
      check("prio_sel_a", 16'(fwd_a_sel_o), 16'd2);
      check("prio_sel_b", 16'(fwd_b_sel_o), 16'd0);

      // Load-use: lw r7 ; add r9 = r1 + r7.
      set_id(1'b1, 5'd2, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0);
      #1;
      check("lu_lw_stall", 16'(stall_o), 16'd0);
      tick();
      set_id(1'b1, 5'd1, 5'd7, 5'd9, 1'b1, 1'b0, 1'b0);
      #1;
      check("lu_stall_on", 16'(stall_o), 16'd1);
      tick();
      #1;
      check("lu_stall_off", 16'(stall_o), 16'd0);
      check("lu_cnt", 16'(stall_cnt_o), 16'd1);
      check("lu_bubble_sel_b", 16'(fwd_b_sel_o), 16'd0);
      tick();
      check("lu_sel_a", 16'(fwd_a_sel_o), 16'd0);
      check("lu_sel_b", 16'(fwd_b_sel_o), 16'd1);
      check("lu_cnt_hold", 16'(stall_cnt_o), 16'd1);
      nop();
      tick();

      // Register 0: lw r0 ; add r4 = r0 + r0.
      set_id(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b0);
      tick();
      set_id(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0);
      #1;
      check("r0_stall", 16'(stall_o), 16'd0);
      tick();
      check("r0_sel_a", 16'(fwd_a_sel_o), 16'd0);
      check("r0_sel_b", 16'(fwd_b_sel_o), 16'd0);
      nop();
      tick();

      // Flush: lw r7 ; add r4 = r7 + r2 flushed ; sub r10 = r4 - r7.
      set_id(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 1'b0);
      tick();
      set_id(1'b1, 5'd7, 5'd2, 5'd4, 1'b1, 1'b0, 1'b1);
      #1;
      check("fl_stall", 16'(stall_o), 16'd0);
      tick();
      check("fl_sel_a", 16'(fwd_a_sel_o), 16'd0);
      set_id(1'b1, 5'd4, 5'd7, 5'd10, 1'b1, 1'b0, 1'b0);
      #1;
      check("fl_next_stall", 16'(stall_o), 16'd0);
      tick();
      check("fl_squash_sel_a", 16'(fwd_a_sel_o), 16'd0);
      check("fl_squash_sel_b", 16'(fwd_b_sel_o), 16'd1);
      check("fl_cnt", 16'(stall_cnt_o), 16'd1);

      // Reset mid-operation: add r3 in flight, then reset, then sub uses r3.
      set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);
      tick();
      rst_i = 1'b1;
      set_id(1'b1, 5'd3, 5'd3, 5'd6, 1'b1, 1'b0, 1'b0);
      tick();
      rst_i = 1'b0;
      #1;
      check("mid_rst_stall", 16'(stall_o), 16'd0);
      check("mid_rst_cnt", 16'(stall_cnt_o), 16'd0);
      tick();
      check("mid_rst_sel_a", 16'(fwd_a_sel_o), 16'd0);
      check("mid_rst_sel_b", 16'(fwd_b_sel_o), 16'd0);
      nop();
      tick();

      // Counter saturation: five load-use pairs with a 2-bit counter.
      for (int i = 0; i < 5; i++) begin
         set_id(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 1'b0);
         tick();
         set_id(1'b1, 5'd7, 5'd7, 5'd9, 1'b1, 1'b0, 1'b0);
         #1;
         check($sformatf("sat_stall_%0d", i), 16'(stall_o), 16'd1);
         tick();
         check($sformatf("sat_cnt_%0d", i), 16'(stall_cnt_o), 16'(exp_sat[i]));
         tick();
      end
      nop();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
